// File: rtl/ysyx_23060025_scoreboard.sv
// Writer-side GPR scoreboard: counts issued-but-uncommitted writes per register
// and stalls decode while any source register still has a pending producer.
module ysyx_23060025_scoreboard #(
   parameter int NREG  = 32,
   parameter int CNT_W = 2,
   parameter int TOT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             idu_valid_i,
   input  logic             idu_ren0_i,
   input  logic [4:0]       idu_rsc0_i,
   input  logic             idu_ren1_i,
   input  logic [4:0]       idu_rsc1_i,
   input  logic             idu_wd_i,
   input  logic [4:0]       idu_wreg_i,
   input  logic             exu_ready_i,
   input  logic             wbu_valid_i,
   input  logic             wbu_wd_i,
   input  logic [4:0]       wbu_wreg_i,
   input  logic             flush_i,
   output logic             sb_stall_o,
   output logic             sb_issue_o,
   output logic [NREG-1:0]  sb_busy_mask_o,
   output logic [TOT_W-1:0] sb_outstanding_o,
   output logic             sb_err_o
);

   localparam logic [CNT_W-1:0] CMAX = '1;
   localparam logic [TOT_W-1:0] TMAX = '1;
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic [TOT_W-1:0] tot_q, tot_d;
   logic             err_q, err_d;

   logic wb_fire, haz0, haz1, sat, tsat, iss_w, same;
   logic [CNT_W-1:0] c_rs0, c_rs1, c_rd, c_wb;

   assign c_rs0 = cnt_q[idu_rsc0_i];
   assign c_rs1 = cnt_q[idu_rsc1_i];
   assign c_rd  = cnt_q[idu_wreg_i];
   assign c_wb  = cnt_q[wbu_wreg_i];

   assign wb_fire = wbu_valid_i & wbu_wd_i & (wbu_wreg_i != '0);

   // A last pending write committing this cycle is forwarded by the
   // write-through register file, so it no longer blocks the reader.
   assign haz0 = idu_ren0_i & (idu_rsc0_i != '0) & (c_rs0 != '0)
              & ~(wb_fire & (wbu_wreg_i == idu_rsc0_i) & (c_rs0 == ONE));
   assign haz1 = idu_ren1_i & (idu_rsc1_i != '0) & (c_rs1 != '0)
              & ~(wb_fire & (wbu_wreg_i == idu_rsc1_i) & (c_rs1 == ONE));

   assign sat  = idu_wd_i & (idu_wreg_i != '0) & (c_rd == CMAX)
              & ~(wb_fire & (wbu_wreg_i == idu_wreg_i));
   assign tsat = (tot_q == TMAX) & ~wb_fire;

   assign sb_stall_o = idu_valid_i & (haz0 | haz1 | sat | tsat);
   assign sb_issue_o = reset & idu_valid_i & ~sb_stall_o
                     & exu_ready_i & ~flush_i;

   assign iss_w = sb_issue_o & idu_wd_i & (idu_wreg_i != '0);
   assign same  = iss_w & wb_fire & (idu_wreg_i == wbu_wreg_i);

   always_comb begin
      cnt_d = cnt_q;
      tot_d = tot_q;
      err_d = err_q;
      if (flush_i) begin
         for (int r = 0; r < NREG; r++) cnt_d[r] = '0;
         tot_d = '0;
      end else if (!same) begin
         if (iss_w) begin
            cnt_d[idu_wreg_i] = c_rd + ONE;
            tot_d = tot_d + TOT_W'(1);
         end
         if (wb_fire) begin
            if (c_wb != '0) begin
               cnt_d[wbu_wreg_i] = c_wb - ONE;
               tot_d = tot_d - TOT_W'(1);
            end else begin
               err_d = 1'b1;
            end
         end
      end
      cnt_d[0] = '0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
         tot_q <= '0;
         err_q <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
         tot_q <= tot_d;
         err_q <= err_d;
      end
   end

   always_comb begin
      sb_busy_mask_o = '0;
      for (int r = 1; r < NREG; r++) sb_busy_mask_o[r] = |cnt_q[r];
   end

   assign sb_outstanding_o = tot_q;
   assign sb_err_o         = err_q;

   int unsigned sum;
   always_comb begin
      sum = 0;
      for (int r = 0; r < NREG; r++) sum = sum + int'(cnt_q[r]);
   end

   a_total_sum: assert property (
      @(posedge clock) disable iff (!reset) int'(tot_q) == sum
   );

endmodule

// File: tb/tb_ysyx_23060025_scoreboard.sv
// Directed bench: expected post-edge state queued at drive time,
// popped and compared after the clock edge.
module tb_ysyx_23060025_scoreboard;

   logic        clock, reset;
   logic        idu_valid_i, idu_ren0_i, idu_ren1_i, idu_wd_i;
   logic [4:0]  idu_rsc0_i, idu_rsc1_i, idu_wreg_i;
   logic        exu_ready_i, wbu_valid_i, wbu_wd_i, flush_i;
   logic [4:0]  wbu_wreg_i;
   logic        sb_stall_o, sb_issue_o, sb_err_o;
   logic [31:0] sb_busy_mask_o;
   logic [3:0]  sb_outstanding_o;

   typedef struct packed {
      logic [31:0] mask;
      logic [3:0]  out;
      logic        err;
   } exp_t;

   exp_t q[$];
   int   ntests = 0;
   int   nfail  = 0;

   ysyx_23060025_scoreboard dut (
      .clock(clock), .reset(reset),
      .idu_valid_i(idu_valid_i),
      .idu_ren0_i(idu_ren0_i), .idu_rsc0_i(idu_rsc0_i),
      .idu_ren1_i(idu_ren1_i), .idu_rsc1_i(idu_rsc1_i),
      .idu_wd_i(idu_wd_i), .idu_wreg_i(idu_wreg_i),
      .exu_ready_i(exu_ready_i),
      .wbu_valid_i(wbu_valid_i), .wbu_wd_i(wbu_wd_i),
      .wbu_wreg_i(wbu_wreg_i), .flush_i(flush_i),
      .sb_stall_o(sb_stall_o), .sb_issue_o(sb_issue_o),
      .sb_busy_mask_o(sb_busy_mask_o),
      .sb_outstanding_o(sb_outstanding_o),
      .sb_err_o(sb_err_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ren0/rs0, ren1/rs1, wd/rd, wb valid(+wd)/rd, flush; then expectations
   task automatic step(
      input string tag, input logic v,
      input logic r0, input logic [4:0] s0,
      input logic r1, input logic [4:0] s1,
      input logic wd, input logic [4:0] rd, input logic rdy,
      input logic wv, input logic [4:0] wr, input logic fl,
      input logic e_stall, input logic e_issue,
      input logic [31:0] e_mask, input logic [3:0] e_out,
      input logic e_err);
      exp_t e;
      @(negedge clock);
      idu_valid_i = v;  idu_ren0_i = r0; idu_rsc0_i = s0;
      idu_ren1_i  = r1; idu_rsc1_i = s1;
      idu_wd_i    = wd; idu_wreg_i = rd; exu_ready_i = rdy;
      wbu_valid_i = wv; wbu_wd_i   = wv; wbu_wreg_i = wr;
      flush_i     = fl;
      e.mask = e_mask; e.out = e_out; e.err = e_err;
      q.push_back(e);
      #1;
      chk({tag, ".stall"}, 32'(sb_stall_o), 32'(e_stall));
      chk({tag, ".issue"}, 32'(sb_issue_o), 32'(e_issue));
      @(posedge clock);
      #1;
      e = q.pop_front();
      chk({tag, ".mask"}, sb_busy_mask_o, e.mask);
      chk({tag, ".out"}, 32'(sb_outstanding_o), 32'(e.out));
      chk({tag, ".err"}, 32'(sb_err_o), 32'(e.err));
   endtask

   initial begin
      reset = 1'b0;
      idu_valid_i = 0; idu_ren0_i = 0; idu_rsc0_i = 0;
      idu_ren1_i = 0;  idu_rsc1_i = 0; idu_wd_i = 0; idu_wreg_i = 0;
      exu_ready_i = 0; wbu_valid_i = 0; wbu_wd_i = 0; wbu_wreg_i = 0;
      flush_i = 0;
      #3;
      chk("rst.stall", 32'(sb_stall_o), 0);
      chk("rst.issue", 32'(sb_issue_o), 0);
      chk("rst.mask", sb_busy_mask_o, 0);
      chk("rst.out", 32'(sb_outstanding_o), 0);
      chk("rst.err", 32'(sb_err_o), 0);
      @(negedge clock);
      reset = 1'b1;

      step("x5", 1, 0,0, 0,0, 1,5, 1, 0,0, 0,  0,1, 32'h20, 1, 0);
      step("raw5", 1, 1,5, 0,0, 0,0, 1, 0,0, 0, 1,0, 32'h20, 1, 0);
      step("wt5", 1, 1,5, 0,0, 0,0, 1, 1,5, 0,  0,1, 32'h0, 0, 0);
      step("x7a", 1, 0,0, 0,0, 1,7, 1, 0,0, 0,  0,1, 32'h80, 1, 0);
      step("x7b", 1, 0,0, 0,0, 1,7, 1, 0,0, 0,  0,1, 32'h80, 2, 0);
      step("x7c", 1, 0,0, 0,0, 1,7, 1, 0,0, 0,  0,1, 32'h80, 3, 0);
      step("sat7", 1, 0,0, 0,0, 1,7, 1, 0,0, 0, 1,0, 32'h80, 3, 0);
      step("sat7wb", 1, 0,0, 0,0, 1,7, 1, 1,7, 0, 0,1, 32'h80, 3, 0);
      step("x9", 1, 0,0, 0,0, 1,9, 1, 0,0, 0,   0,1, 32'h280, 4, 0);
      step("x9net", 1, 0,0, 0,0, 1,9, 1, 1,9, 0, 0,1, 32'h280, 4, 0);
      step("x10", 1, 0,0, 0,0, 1,10, 1, 0,0, 0, 0,1, 32'h680, 5, 0);
      step("x11", 1, 0,0, 0,0, 1,11, 1, 0,0, 0, 0,1, 32'hE80, 6, 0);
      step("raw9", 1, 0,0, 1,9, 0,0, 1, 0,0, 0,  1,0, 32'hE80, 6, 0);
      step("flush", 1, 0,0, 0,0, 1,13, 1, 0,0, 1, 0,0, 32'h0, 0, 0);
      step("undf12", 0, 0,0, 0,0, 0,0, 0, 1,12, 0, 0,0, 32'h0, 0, 1);
      step("flerr", 0, 0,0, 0,0, 0,0, 0, 0,0, 1,  0,0, 32'h0, 0, 1);
      step("x3", 1, 0,0, 1,0, 1,3, 1, 0,0, 0,    0,1, 32'h8, 1, 1);
      step("x0w", 1, 1,0, 0,0, 1,0, 1, 0,0, 0,   0,1, 32'h8, 1, 1);
      step("nov", 0, 1,3, 0,0, 0,0, 1, 0,0, 0,   0,0, 32'h8, 1, 1);
      step("nrdy", 1, 1,4, 0,0, 1,4, 0, 0,0, 0,  0,0, 32'h8, 1, 1);

      @(negedge clock);
      idu_valid_i = 1; idu_ren0_i = 1; idu_rsc0_i = 3;
      idu_wd_i = 0; exu_ready_i = 1;
      #1;
      chk("pre.stall", 32'(sb_stall_o), 1);
      reset = 1'b0;
      #1;
      chk("mid.stall", 32'(sb_stall_o), 0);
      chk("mid.issue", 32'(sb_issue_o), 0);
      chk("mid.mask", sb_busy_mask_o, 0);
      chk("mid.out", 32'(sb_outstanding_o), 0);
      chk("mid.err", 32'(sb_err_o), 0);
      @(negedge clock);
      reset = 1'b1;
      idu_valid_i = 0;
      @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
